// File: rtl/stdp_weight_update.sv
// Single-synapse STDP learning rule with exponential-style pre/post traces.
// Optional macro STDP_WEIGHT_LOAD_EN adds a direct weight load port (w_load, w_data).
module stdp_weight_update #(
   parameter int unsigned W_INIT      = 64,
   parameter int unsigned W_MAX       = 200,
   parameter int unsigned TRACE_SET   = 128,
   parameter int unsigned DECAY_SHIFT = 2,
   parameter int unsigned LTP_SHIFT   = 3,
   parameter int unsigned LTD_SHIFT   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pre_spike,
   input  logic       post_spike,
   input  logic       learn_en,
`ifdef STDP_WEIGHT_LOAD_EN
   input  logic       w_load,
   input  logic [7:0] w_data,
`endif
   output logic [7:0] current,
   output logic [7:0] weight,
   output logic [7:0] pre_trace,
   output logic [7:0] post_trace,
   output logic       ltp_pulse,
   output logic       ltd_pulse
);

   localparam int unsigned DW = 8;
   localparam int unsigned SW = 10;
   localparam logic signed [SW-1:0] W_MAX_S = SW'(W_MAX);

   logic [DW-1:0]        pre_trace_next, post_trace_next;
   logic [DW-1:0]        ltp, ltd;
   logic signed [SW-1:0] w_sum;
   logic [DW-1:0]        weight_next, current_next;
   logic                 ltp_next, ltd_next;

   // Spike reloads the trace; otherwise it decays geometrically and snaps to 0 when small.
   function automatic logic [DW-1:0] trace_step(input logic spike, input logic [DW-1:0] t);
      if (spike)
         return DW'(TRACE_SET);
      else if (t < DW'(1 << DECAY_SHIFT))
         return '0;
      else
         return t - (t >> DECAY_SHIFT);
   endfunction

   always_comb begin
      pre_trace_next  = trace_step(pre_spike, pre_trace);
      post_trace_next = trace_step(post_spike, post_trace);
      ltp             = post_spike ? (pre_trace >> LTP_SHIFT) : '0;
      ltd             = pre_spike ? (post_trace >> LTD_SHIFT) : '0;
      w_sum           = SW'(weight) + SW'(ltp) - SW'(ltd);
      current_next    = pre_spike ? weight : '0;
      weight_next     = weight;
      ltp_next        = 1'b0;
      ltd_next        = 1'b0;
      if (learn_en) begin
         if (w_sum[SW-1])
            weight_next = '0;
         else if (w_sum > W_MAX_S)
            weight_next = DW'(W_MAX);
         else
            weight_next = w_sum[DW-1:0];
         ltp_next = (ltp != '0);
         ltd_next = (ltd != '0);
      end
`ifdef STDP_WEIGHT_LOAD_EN
      // Direct load wins over learning and silences the event flags.
      if (w_load) begin
         weight_next = (w_data > DW'(W_MAX)) ? DW'(W_MAX) : w_data;
         ltp_next    = 1'b0;
         ltd_next    = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         weight     <= DW'(W_INIT);
         pre_trace  <= '0;
         post_trace <= '0;
         current    <= '0;
         ltp_pulse  <= 1'b0;
         ltd_pulse  <= 1'b0;
      end else begin
         weight     <= weight_next;
         pre_trace  <= pre_trace_next;
         post_trace <= post_trace_next;
         current    <= current_next;
         ltp_pulse  <= ltp_next;
         ltd_pulse  <= ltd_next;
      end
   end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Randomized bench for stdp_weight_update against an integer reference model of the STDP rule.
module tb_stdp_weight_update;

   localparam int W_INIT = 64, W_MAX = 200, TRACE_SET = 128;
   localparam int DECAY_SHIFT = 2, LTP_SHIFT = 3, LTD_SHIFT = 4;

   logic       clk = 1'b0;
   logic       rst_n, pre_spike, post_spike, learn_en;
   logic       w_load;
   logic [7:0] w_data;
   logic [7:0] current, weight, pre_trace, post_trace;
   logic       ltp_pulse, ltd_pulse;

   int errors = 0;
   int checks = 0;

   // reference state
   int m_w, m_pt, m_qt, m_cur, m_ltp, m_ltd;

   always #5 clk = ~clk;

   stdp_weight_update #(
      .W_INIT(W_INIT), .W_MAX(W_MAX), .TRACE_SET(TRACE_SET),
      .DECAY_SHIFT(DECAY_SHIFT), .LTP_SHIFT(LTP_SHIFT), .LTD_SHIFT(LTD_SHIFT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
      .learn_en(learn_en),
`ifdef STDP_WEIGHT_LOAD_EN
      .w_load(w_load), .w_data(w_data),
`endif
      .current(current), .weight(weight), .pre_trace(pre_trace),
      .post_trace(post_trace), .ltp_pulse(ltp_pulse), .ltd_pulse(ltd_pulse)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int decay(input bit spike, input int t);
      if (spike) return TRACE_SET;
      if (t < (1 << DECAY_SHIFT)) return 0;
      return t - t / (1 << DECAY_SHIFT);
   endfunction

   task automatic model_update(input bit rst, input bit pre, input bit post,
                               input bit learn, input bit ld, input int d);
      int ltp, ltd, nw;
      if (!rst) begin
         m_w = W_INIT; m_pt = 0; m_qt = 0; m_cur = 0; m_ltp = 0; m_ltd = 0;
         return;
      end
      ltp   = post ? m_pt / (1 << LTP_SHIFT) : 0;
      ltd   = pre ? m_qt / (1 << LTD_SHIFT) : 0;
      m_cur = pre ? m_w : 0;
      m_ltp = learn && ltp != 0;
      m_ltd = learn && ltd != 0;
      if (learn) begin
         nw  = m_w + ltp - ltd;
         m_w = nw < 0 ? 0 : (nw > W_MAX ? W_MAX : nw);
      end
      if (ld) begin
         m_w = d > W_MAX ? W_MAX : d;
         m_ltp = 0; m_ltd = 0;
      end
      m_pt = decay(pre, m_pt);
      m_qt = decay(post, m_qt);
   endtask

   // One clock: drive on the falling edge, advance model on the rising edge, compare 1 time unit later.
   task automatic step(input bit rst, input bit pre, input bit post, input bit learn,
                       input bit ld = 1'b0, input int d = 0);
      @(negedge clk);
      rst_n = rst; pre_spike = pre; post_spike = post; learn_en = learn;
`ifdef STDP_WEIGHT_LOAD_EN
      w_load = ld; w_data = 8'(d);
`else
      w_load = 1'b0; w_data = 8'd0;
      ld = 1'b0;
`endif
      @(posedge clk);
      model_update(rst, pre, post, learn, ld, d);
      #1;
      check("weight", int'(weight), m_w);
      check("pre_trace", int'(pre_trace), m_pt);
      check("post_trace", int'(post_trace), m_qt);
      check("current", int'(current), m_cur);
      check("ltp_pulse", int'(ltp_pulse), m_ltp);
      check("ltd_pulse", int'(ltd_pulse), m_ltd);
   endtask

   initial begin
      rst_n = 1'b0; pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b1;
      w_load = 1'b0; w_data = 8'd0;
      m_w = W_INIT; m_pt = 0; m_qt = 0; m_cur = 0; m_ltp = 0; m_ltd = 0;

      // reset with toggling spikes
      step(0, 1, 0, 1);
      step(0, 0, 1, 1);
      check("rst_weight", int'(weight), 64);
      check("rst_traces", int'(pre_trace) + int'(post_trace), 0);
      check("rst_current", int'(current), 0);
      check("rst_pulses", int'(ltp_pulse) + int'(ltd_pulse), 0);

      // pre then post
      step(1, 1, 0, 1);
      check("pp_pre_trace0", int'(pre_trace), 128);
      check("pp_current", int'(current), 64);
      step(1, 0, 1, 1);
      check("pp_weight", int'(weight), 80);
      check("pp_ltp", int'(ltp_pulse), 1);
      check("pp_pre_trace1", int'(pre_trace), 96);
      step(1, 0, 0, 1);
      check("pp_pre_trace2", int'(pre_trace), 72);
      step(1, 0, 0, 1);
      check("pp_pre_trace3", int'(pre_trace), 54);

      // post then pre
      step(0, 0, 0, 1);
      step(1, 0, 1, 1);
      check("qp_post_trace", int'(post_trace), 128);
      step(1, 1, 0, 1);
      check("qp_weight", int'(weight), 56);
      check("qp_ltd", int'(ltd_pulse), 1);
      check("qp_current", int'(current), 64);

      // simultaneous spikes from zero traces
      step(0, 0, 0, 1);
      step(1, 1, 1, 1);
      check("sim_weight", int'(weight), 64);
      check("sim_pulses", int'(ltp_pulse) + int'(ltd_pulse), 0);
      check("sim_traces", int'(pre_trace) + int'(post_trace), 256);

      // learning disabled: alternating spikes
      step(0, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(1, i % 2 == 0, i % 2 == 1, 0);
      check("nolearn_weight", int'(weight), 64);

      // upper saturation through repeated potentiation
      step(0, 0, 0, 1);
      for (int i = 0; i < 25; i++) begin
         step(1, 1, 0, 1);
         step(1, 0, 1, 1);
      end
      check("sat_hi_weight", int'(weight), 200);
      check("sat_hi_ltp", int'(ltp_pulse), 1);

      // lower saturation: charge post trace with learning off, then depress
      for (int i = 0; i < 30; i++) begin
         step(1, 0, 1, 0);
         step(1, 1, 0, 1);
      end
      check("sat_lo_weight", int'(weight), 0);
      check("sat_lo_ltd", int'(ltd_pulse), 1);

`ifdef STDP_WEIGHT_LOAD_EN
      step(0, 0, 0, 1);
      step(1, 1, 0, 1, 1, 195);
      check("load_195", int'(weight), 195);
      step(1, 0, 1, 1);
      check("load_hi_weight", int'(weight), 200);
      check("load_hi_ltp", int'(ltp_pulse), 1);
      step(1, 0, 1, 1, 1, 3);
      step(1, 1, 0, 1);
      check("load_lo_weight", int'(weight), 0);
      check("load_lo_ltd", int'(ltd_pulse), 1);
      step(1, 1, 1, 1, 1, 250);
      check("load_clip", int'(weight), 200);
`endif

      // randomized traffic
      step(0, 0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 50) != 0, ($urandom % 10) < 3, ($urandom % 10) < 3,
              ($urandom % 10) < 8, ($urandom % 30) == 0, int'($urandom % 256));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stdp_weight_update.md
STDP_WEIGHT_UPDATE -- requirements
Module: stdp_weight_update

Interface
REQ-001 SHALL have parameter W_INIT, 64, weight value loaded at reset.
REQ-002 SHALL have parameter W_MAX, 200, upper weight saturation bound; the lower bound is fixed at 0.
REQ-003 SHALL have parameter TRACE_SET, 128, trace value loaded on a spike.
REQ-004 SHALL have parameter DECAY_SHIFT, 2, trace decay shift.
REQ-005 SHALL have parameter LTP_SHIFT, 3, potentiation scaling shift.
REQ-006 SHALL have parameter LTD_SHIFT, 4, depression scaling shift.
REQ-007 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-009 SHALL have port pre_spike, input, 1, presynaptic spike, one cycle per event.
REQ-010 SHALL have port post_spike, input, 1, postsynaptic spike from the downstream LIF neuron.
REQ-011 SHALL have port learn_en, input, 1, enables weight plasticity.
REQ-012 SHALL have port current, output, 8, synaptic current driving the downstream LIF current input.
REQ-013 SHALL have port weight, output, 8, registered synaptic weight.
REQ-014 SHALL have port pre_trace, output, 8, registered presynaptic trace.
REQ-015 SHALL have port post_trace, output, 8, registered postsynaptic trace.
REQ-016 SHALL have port ltp_pulse, output, 1, one-cycle potentiation event flag.
REQ-017 SHALL have port ltd_pulse, output, 1, one-cycle depression event flag.

Function
REQ-018 Trace update, applied to each trace independently every cycle: spike on the matching input -> TRACE_SET; else if trace < 2^DECAY_SHIFT -> 0; else trace - (trace >> DECAY_SHIFT).
REQ-019 Deltas SHALL use the registered traces from before this cycle's update: ltp = post_spike ? (pre_trace >> LTP_SHIFT) : 0; ltd = pre_spike ? (post_trace >> LTD_SHIFT) : 0.
REQ-020 When learn_en=1, the next weight SHALL be clamp(weight + ltp - ltd, 0, W_MAX), computed in at least 10-bit signed arithmetic with no wrap-around.
REQ-021 When learn_en=0, weight SHALL hold; traces SHALL still update.
REQ-022 Simultaneous pre_spike and post_spike: both deltas apply in the same cycle (net sum), then both traces are set to TRACE_SET.
REQ-023 ltp_pulse SHALL assert the cycle after post_spike when learn_en=1 and ltp != 0, even if the weight saturates.
REQ-024 ltd_pulse SHALL assert the cycle after pre_spike when learn_en=1 and ltd != 0, even if the weight saturates.
REQ-025 current SHALL be registered as pre_spike ? weight : 0, using the weight from before this cycle's update (1-cycle latency).
REQ-026 current SHALL be 0 in every cycle that does not follow a pre_spike.

Reset
REQ-027 When rst_n=0 at a clock edge: weight=W_INIT; pre_trace=0; post_trace=0; current=0; ltp_pulse=0; ltd_pulse=0.
REQ-028 Reset SHALL override all other inputs, including mid-update; spikes in the reset cycle SHALL be discarded.

Configuration
REQ-029 Macro STDP_WEIGHT_LOAD_EN defined: add input w_load (1 bit) and input w_data (8 bits).
REQ-030 With STDP_WEIGHT_LOAD_EN, w_load=1 sets weight = min(w_data, W_MAX), overriding learning and suppressing both pulses; traces update normally.
REQ-031 Macro STDP_WEIGHT_LOAD_EN undefined: w_load and w_data SHALL be absent, with behaviour otherwise identical.

Verification
REQ-032 Reset: rst_n=0 for 2 cycles with spikes toggling -> weight=64, traces=0, current=0, pulses=0.
REQ-033 Pre then post: pre at t0 -> pre_trace 128, 96, 72, 54; post at t1 (pre_trace=128) -> weight 80 and ltp_pulse=1 at t2; current=64 at t1.
REQ-034 Post then pre: post at t0, pre at t1 (post_trace=128) -> weight 56 and ltd_pulse=1 at t2; current=64 at t2.
REQ-035 Simultaneous spikes with both traces 0 -> weight unchanged, no pulses, both traces 128 next cycle.
REQ-036 Saturation (STDP_WEIGHT_LOAD_EN): load 195, pre_trace=128, post -> weight 200; load 3, post_trace=128, pre -> weight 0; ltp_pulse and ltd_pulse still assert.
REQ-037 learn_en=0 with alternating pre/post over 20 cycles -> weight constant at 64, traces follow REQ-018, pulses 0.
